// File: rtl/negacyclic_fold.sv
// Folds 2*DIMENSION+1 raw product coefficients modulo x^(DIMENSION+1)+1 and streams out DIMENSION+1 residues mod q.
// Optional macro NEGACYCLIC_FOLD_CENTERED_EN: present out_coeff in centered two's-complement form.
module negacyclic_fold #(
  parameter int unsigned CIPHERTEXT_MODULUS = 1024,
  parameter int unsigned CIPHERTEXT_WIDTH   = 10,
  parameter int unsigned DIMENSION          = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0] in_coeff,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CIPHERTEXT_WIDTH-1:0] out_coeff,
  output logic [DIMENSION:0]          out_index,
  output logic                        out_last,
  output logic                        err
);

  localparam int unsigned W   = CIPHERTEXT_WIDTH;
  localparam int unsigned W1  = CIPHERTEXT_WIDTH + 1;
  localparam int unsigned NI  = 2 * DIMENSION + 1;
  localparam int unsigned KW  = (NI > 1) ? $clog2(NI) : 1;
  localparam int unsigned JW  = (DIMENSION > 0) ? $clog2(DIMENSION + 1) : 1;
  localparam int unsigned IW  = DIMENSION + 1;

  localparam logic [W:0]    Q      = W1'(CIPHERTEXT_MODULUS);
  localparam logic [W:0]    HALF   = W1'(CIPHERTEXT_MODULUS / 2);
  localparam logic [KW-1:0] K_LAST = KW'(2 * DIMENSION);
  localparam logic [KW-1:0] K_FOLD = KW'(DIMENSION + 1);
  localparam logic [KW-1:0] K_MID  = KW'(DIMENSION);
  localparam logic [JW-1:0] J_LAST = JW'(DIMENSION);

  localparam logic [0:0] S_ACCEPT = 1'b0;
  localparam logic [0:0] S_DRAIN  = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic [JW-1:0] r_j, w_j_nxt;
  logic          r_err, w_err_nxt;
  logic [W-1:0]  r_buf [0:DIMENSION];

  logic          w_fold;
  logic [JW-1:0] w_slot;
  logic [W:0]    w_diff;
  logic [W-1:0]  w_modsub;
  logic          w_wr_en;
  logic [W-1:0]  w_wr_data;
  logic [W-1:0]  w_out_val;
  logic [W-1:0]  w_out_fmt;
  logic          w_draining;

  // Upper-half coefficients land on slot k-DIMENSION-1 with a negative sign.
  assign w_fold   = (r_k > K_MID);
  assign w_slot   = w_fold ? JW'(r_k - K_FOLD) : JW'(r_k);

  // Borrow out of the W+1-bit difference selects the +q correction.
  assign w_diff   = {1'b0, r_buf[w_slot]} - {1'b0, in_coeff};
  assign w_modsub = w_diff[W] ? W'(w_diff + Q) : w_diff[W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_j_nxt     = r_j;
    w_err_nxt   = r_err;
    w_wr_en     = 1'b0;
    w_wr_data   = in_coeff;
    case (r_state)
      S_ACCEPT: begin
        if (in_valid) begin
          w_wr_en   = 1'b1;
          w_wr_data = w_fold ? w_modsub : in_coeff;
          if (in_last != (r_k == K_LAST)) begin
            w_err_nxt = 1'b1;
          end
          if (r_k == K_LAST) begin
            w_state_nxt = S_DRAIN;
            w_k_nxt     = '0;
          end else begin
            w_k_nxt = r_k + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (r_j == J_LAST) begin
            w_state_nxt = S_ACCEPT;
            w_j_nxt     = '0;
          end else begin
            w_j_nxt = r_j + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCEPT;
      r_k     <= '0;
      r_j     <= '0;
      r_err   <= 1'b0;
      for (int unsigned i = 0; i < IW; i++) begin
        r_buf[JW'(i)] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_j     <= w_j_nxt;
      r_err   <= w_err_nxt;
      if (w_wr_en) begin
        r_buf[w_slot] <= w_wr_data;
      end
    end
  end

  assign w_draining = (r_state == S_DRAIN);
  assign w_out_val  = r_buf[r_j];

`ifdef NEGACYCLIC_FOLD_CENTERED_EN
  // Residues above floor(q/2) map to v-q, reinterpreted as two's complement.
  assign w_out_fmt = ({1'b0, w_out_val} > HALF) ? W'({1'b0, w_out_val} - Q) : w_out_val;
`else
  assign w_out_fmt = w_out_val;
`endif

  assign in_ready  = (r_state == S_ACCEPT);
  assign out_valid = w_draining;
  assign out_coeff = w_draining ? w_out_fmt : '0;
  assign out_index = w_draining ? IW'(r_j) : '0;
  assign out_last  = w_draining && (r_j == J_LAST);
  assign err       = r_err;

endmodule

// File: tb/tb_negacyclic_fold.sv
// Self-checking bench for negacyclic_fold: two instances (q=1024/W=10 and q=17/W=5, D=1) driven in lockstep.
module tb_negacyclic_fold;

  localparam int D  = 1;
  localparam int NI = 2 * D + 1;
  localparam int NO = D + 1;
  localparam int QA = 1024;
  localparam int WA = 10;
  localparam int QB = 17;
  localparam int WB = 5;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic in_valid  = 1'b0;
  logic in_last   = 1'b0;
  logic out_ready = 1'b0;

  logic [WA-1:0] a_in_coeff = '0;
  logic          a_in_ready, a_out_valid, a_out_last, a_err;
  logic [WA-1:0] a_out_coeff;
  logic [D:0]    a_out_index;

  logic [WB-1:0] b_in_coeff = '0;
  logic          b_in_ready, b_out_valid, b_out_last, b_err;
  logic [WB-1:0] b_out_coeff;
  logic [D:0]    b_out_index;

  int errors = 0;
  int checks = 0;

  int ga[NO], gb[NO], gidxa[NO], gidxb[NO], glast[NO], gvalid[NO], ginrdy[NO];
  int inrdy_ok, stall_ok, post_inrdy, post_outvalid;

  always #5 clk = ~clk;

  negacyclic_fold #(.CIPHERTEXT_MODULUS(QA), .CIPHERTEXT_WIDTH(WA), .DIMENSION(D)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_coeff(a_in_coeff), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_coeff(a_out_coeff), .out_index(a_out_index), .out_last(a_out_last), .err(a_err)
  );

  negacyclic_fold #(.CIPHERTEXT_MODULUS(QB), .CIPHERTEXT_WIDTH(WB), .DIMENSION(D)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_coeff(b_in_coeff), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_coeff(b_out_coeff), .out_index(b_out_index), .out_last(b_out_last), .err(b_err)
  );

  // Reference: polynomial reduction mod x^(D+1)+1, coefficients mod q, optional centering.
  function automatic int fold_ref(input int v[NI], input int idx, input int q, input int w);
    int acc;
    acc = v[idx] % q;
    for (int k = D + 1; k < NI; k++) begin
      if (k - D - 1 == idx) acc = (((acc - v[k]) % q) + q) % q;
    end
`ifdef NEGACYCLIC_FOLD_CENTERED_EN
    if (acc > q / 2) acc = (acc - q) & ((1 << w) - 1);
`endif
    return acc;
  endfunction

  function automatic int rand_coeff(input int q);
    int r;
    r = int'($urandom_range(9));
    if (r == 0) return 0;
    if (r == 1) return q - 1;
    return int'($urandom_range(q - 1));
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs(input int va[NI], input int vb[NI], input int last_pos);
    inrdy_ok = 1;
    for (int i = 0; i < NI; i++) begin
      in_valid   = 1'b1;
      a_in_coeff = WA'(va[i]);
      b_in_coeff = WB'(vb[i]);
      in_last    = (i == last_pos);
      if (!(a_in_ready && b_in_ready)) inrdy_ok = 0;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int stall);
    int fa, fb;
    out_ready = 1'b0;
    stall_ok  = 1;
    fa = int'(a_out_coeff);
    fb = int'(b_out_coeff);
    for (int s = 0; s < stall; s++) begin
      if (!(a_out_valid && b_out_valid) || a_out_index != 0 || b_out_index != 0 ||
          a_in_ready || b_in_ready || int'(a_out_coeff) != fa || int'(b_out_coeff) != fb)
        stall_ok = 0;
      step();
    end
    out_ready = 1'b1;
    for (int j = 0; j < NO; j++) begin
      gvalid[j] = int'(a_out_valid && b_out_valid);
      ga[j]     = int'(a_out_coeff);
      gb[j]     = int'(b_out_coeff);
      gidxa[j]  = int'(a_out_index);
      gidxb[j]  = int'(b_out_index);
      glast[j]  = int'({a_out_last, b_out_last});
      ginrdy[j] = int'(a_in_ready || b_in_ready);
      step();
    end
    post_inrdy    = int'(a_in_ready && b_in_ready);
    post_outvalid = int'(a_out_valid || b_out_valid);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b/%b want 1", a_in_ready, b_in_ready); end
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b/%b want 0", a_out_valid, b_out_valid); end
    checks++; if (a_out_coeff !== '0 || a_out_index !== '0 || a_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_data: got %0d/%0d/%b want 0", a_out_coeff, a_out_index, a_out_last); end
    checks++; if (a_err !== 1'b0 || b_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b want 0", a_err, b_err); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed;
    int va[NI], vb[NI];
    va = '{5, 7, 3};
    vb = '{2, 16, 5};
    drive_inputs(va, vb, NI - 1);
    drain(0);
    checks++; if (inrdy_ok != 1) begin errors++; $display("FAIL dir1_in_ready: got %0d want 1", inrdy_ok); end
    for (int j = 0; j < NO; j++) begin
      checks++; if (gvalid[j] != 1) begin errors++; $display("FAIL dir1_valid[%0d]: got %0d want 1", j, gvalid[j]); end
      checks++; if (ga[j] != fold_ref(va, j, QA, WA)) begin errors++; $display("FAIL dir1_a[%0d]: got %0d want %0d", j, ga[j], fold_ref(va, j, QA, WA)); end
      checks++; if (gb[j] != fold_ref(vb, j, QB, WB)) begin errors++; $display("FAIL dir1_b[%0d]: got %0d want %0d", j, gb[j], fold_ref(vb, j, QB, WB)); end
      checks++; if (gidxa[j] != j || gidxb[j] != j) begin errors++; $display("FAIL dir1_index[%0d]: got %0d/%0d want %0d", j, gidxa[j], gidxb[j], j); end
      checks++; if (glast[j] != ((j == D) ? 3 : 0)) begin errors++; $display("FAIL dir1_last[%0d]: got %0d want %0d", j, glast[j], (j == D) ? 3 : 0); end
    end
    checks++; if (ga[0] != 2 || ga[1] != 7) begin errors++; $display("FAIL dir1_literal: got %0d,%0d want 2,7", ga[0], ga[1]); end
    checks++; if (a_err !== 1'b0 || b_err !== 1'b0) begin errors++; $display("FAIL dir1_err: got %b/%b want 0", a_err, b_err); end

    va = '{1, 0, 4};
    vb = '{9, 0, 9};
    drive_inputs(va, vb, NI - 1);
    drain(0);
    checks++; if (ga[0] != 1021 || ga[1] != 0) begin errors++; $display("FAIL dir2_wrap_a: got %0d,%0d want 1021,0", ga[0], ga[1]); end
    checks++; if (gb[0] != fold_ref(vb, 0, QB, WB) || gb[1] != fold_ref(vb, 1, QB, WB)) begin errors++; $display("FAIL dir2_b: got %0d,%0d want %0d,%0d", gb[0], gb[1], fold_ref(vb, 0, QB, WB), fold_ref(vb, 1, QB, WB)); end
    checks++; if (gb[0] != 0) begin errors++; $display("FAIL dir2_zero_b: got %0d want 0", gb[0]); end

    va = '{0, 3, 0};
    vb = '{2, 16, 5};
    drive_inputs(va, vb, NI - 1);
    drain(0);
    checks++; if (ga[0] != 0 || ga[1] != fold_ref(va, 1, QA, WA)) begin errors++; $display("FAIL dir3_a: got %0d,%0d want 0,%0d", ga[0], ga[1], fold_ref(va, 1, QA, WA)); end
    checks++; if (gb[0] != fold_ref(vb, 0, QB, WB) || gb[1] != fold_ref(vb, 1, QB, WB)) begin errors++; $display("FAIL dir3_b: got %0d,%0d want %0d,%0d", gb[0], gb[1], fold_ref(vb, 0, QB, WB), fold_ref(vb, 1, QB, WB)); end
  endtask

  task automatic test_random;
    int va[NI], vb[NI];
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NI; i++) begin
        va[i] = rand_coeff(QA);
        vb[i] = rand_coeff(QB);
      end
      drive_inputs(va, vb, NI - 1);
      drain(int'($urandom_range(2)));
      checks++; if (inrdy_ok != 1 || stall_ok != 1) begin errors++; $display("FAIL rnd%0d_handshake: got %0d/%0d want 1/1", n, inrdy_ok, stall_ok); end
      for (int j = 0; j < NO; j++) begin
        checks++; if (gvalid[j] != 1 || gidxa[j] != j || glast[j] != ((j == D) ? 3 : 0)) begin errors++; $display("FAIL rnd%0d_ctrl[%0d]: got v=%0d i=%0d l=%0d", n, j, gvalid[j], gidxa[j], glast[j]); end
        checks++; if (ga[j] != fold_ref(va, j, QA, WA)) begin errors++; $display("FAIL rnd%0d_a[%0d]: got %0d want %0d", n, j, ga[j], fold_ref(va, j, QA, WA)); end
        checks++; if (gb[j] != fold_ref(vb, j, QB, WB)) begin errors++; $display("FAIL rnd%0d_b[%0d]: got %0d want %0d", n, j, gb[j], fold_ref(vb, j, QB, WB)); end
      end
    end
    checks++; if (a_err !== 1'b0 || b_err !== 1'b0) begin errors++; $display("FAIL rnd_err: got %b/%b want 0", a_err, b_err); end
  endtask

  task automatic test_backpressure;
    int va[NI], vb[NI];
    for (int i = 0; i < NI; i++) begin
      va[i] = rand_coeff(QA);
      vb[i] = rand_coeff(QB);
    end
    drive_inputs(va, vb, NI - 1);
    drain(4);
    checks++; if (stall_ok != 1) begin errors++; $display("FAIL bp_stall_hold: got %0d want 1", stall_ok); end
    for (int j = 0; j < NO; j++) begin
      checks++; if (gvalid[j] != 1 || ginrdy[j] != 0) begin errors++; $display("FAIL bp_beat[%0d]: got valid=%0d in_ready=%0d want 1/0", j, gvalid[j], ginrdy[j]); end
      checks++; if (ga[j] != fold_ref(va, j, QA, WA) || gb[j] != fold_ref(vb, j, QB, WB)) begin errors++; $display("FAIL bp_data[%0d]: got %0d/%0d want %0d/%0d", j, ga[j], gb[j], fold_ref(va, j, QA, WA), fold_ref(vb, j, QB, WB)); end
    end
    checks++; if (post_inrdy != 1 || post_outvalid != 0) begin errors++; $display("FAIL bp_return: got in_ready=%0d out_valid=%0d want 1/0", post_inrdy, post_outvalid); end
  endtask

  task automatic test_framing;
    int va[NI], vb[NI];
    va = '{100, 200, 300};
    vb = '{4, 6, 11};
    drive_inputs(va, vb, 1);
    drain(0);
    checks++; if (a_err !== 1'b1 || b_err !== 1'b1) begin errors++; $display("FAIL frm_early_err: got %b/%b want 1", a_err, b_err); end
    checks++; if (ga[0] != fold_ref(va, 0, QA, WA) || ga[1] != fold_ref(va, 1, QA, WA)) begin errors++; $display("FAIL frm_early_a: got %0d,%0d want %0d,%0d", ga[0], ga[1], fold_ref(va, 0, QA, WA), fold_ref(va, 1, QA, WA)); end
    checks++; if (gb[0] != fold_ref(vb, 0, QB, WB) || glast[1] != 3) begin errors++; $display("FAIL frm_early_b: got %0d last=%0d want %0d last=3", gb[0], glast[1], fold_ref(vb, 0, QB, WB)); end

    va = '{8, 9, 10};
    vb = '{1, 2, 3};
    drive_inputs(va, vb, NI - 1);
    drain(0);
    checks++; if (a_err !== 1'b1 || b_err !== 1'b1) begin errors++; $display("FAIL frm_sticky: got %b/%b want 1", a_err, b_err); end
    checks++; if (ga[0] != fold_ref(va, 0, QA, WA) || gb[0] != fold_ref(vb, 0, QB, WB)) begin errors++; $display("FAIL frm_clean_data: got %0d/%0d want %0d/%0d", ga[0], gb[0], fold_ref(va, 0, QA, WA), fold_ref(vb, 0, QB, WB)); end

    rst_n = 1'b0;
    #1;
    checks++; if (a_err !== 1'b0 || b_err !== 1'b0) begin errors++; $display("FAIL frm_reset_clear: got %b/%b want 0", a_err, b_err); end
    step();
    rst_n = 1'b1;
    step();

    drive_inputs(va, vb, -1);
    drain(0);
    checks++; if (a_err !== 1'b1 || b_err !== 1'b1) begin errors++; $display("FAIL frm_missing_last: got %b/%b want 1", a_err, b_err); end
    checks++; if (ga[1] != fold_ref(va, 1, QA, WA)) begin errors++; $display("FAIL frm_missing_data: got %0d want %0d", ga[1], fold_ref(va, 1, QA, WA)); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid;
    int va[NI], vb[NI];
    in_valid   = 1'b1;
    a_in_coeff = WA'(77);
    b_in_coeff = WB'(13);
    step();
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_prod_state: got in_ready=%b out_valid=%b want 1/0", a_in_ready, a_out_valid); end
    step();
    rst_n = 1'b1;
    step();
    va = '{6, 1, 2};
    vb = '{3, 5, 7};
    drive_inputs(va, vb, NI - 1);
    drain(0);
    checks++; if (ga[0] != fold_ref(va, 0, QA, WA) || ga[1] != fold_ref(va, 1, QA, WA)) begin errors++; $display("FAIL rmid_prod_a: got %0d,%0d want %0d,%0d", ga[0], ga[1], fold_ref(va, 0, QA, WA), fold_ref(va, 1, QA, WA)); end
    checks++; if (gb[0] != fold_ref(vb, 0, QB, WB) || gb[1] != fold_ref(vb, 1, QB, WB)) begin errors++; $display("FAIL rmid_prod_b: got %0d,%0d want %0d,%0d", gb[0], gb[1], fold_ref(vb, 0, QB, WB), fold_ref(vb, 1, QB, WB)); end

    va = '{50, 60, 70};
    vb = '{10, 11, 12};
    drive_inputs(va, vb, NI - 1);
    out_ready = 1'b1;
    step();
    checks++; if (a_out_valid !== 1'b1 || a_out_index !== 2'd1) begin errors++; $display("FAIL rmid_drain_beat1: got valid=%b index=%0d want 1/1", a_out_valid, a_out_index); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain_valid: got %b/%b want 0", a_out_valid, b_out_valid); end
    checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL rmid_drain_ready: got %b/%b want 1", a_in_ready, b_in_ready); end
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle_valid: got %b/%b want 0", a_out_valid, b_out_valid); end
    va = '{4, 4, 4};
    vb = '{4, 4, 4};
    drive_inputs(va, vb, NI - 1);
    drain(0);
    checks++; if (ga[0] != 0 || ga[1] != 4 || gb[0] != 0 || gb[1] != 4) begin errors++; $display("FAIL rmid_refill: got %0d,%0d/%0d,%0d want 0,4/0,4", ga[0], ga[1], gb[0], gb[1]); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_framing();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
